// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined adder/subtractor: the lower half is added in S1, the upper half in S2,
// each half built from GROUP-bit carry-lookahead groups chained by ripple carry.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;
    localparam int NGRP = HALF / GROUP;

    // One lookahead group: every internal carry is a flat sum of products of g/p and ci.
    function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             prod;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < GROUP; k++) begin
            c[k+1] = g[k];
            prod   = p[k];
            for (int j = k - 1; j >= 0; j--) begin
                c[k+1] = c[k+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[k+1] = c[k+1] | (prod & ci);
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    // Half-width adder: lookahead inside each group, ripple between groups.
    function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                               input logic [HALF-1:0] y,
                                               input logic            ci);
        logic [HALF-1:0] s;
        logic            c;
        logic [GROUP:0]  r;
        s = '0;
        c = ci;
        for (int gi = 0; gi < NGRP; gi++) begin
            r = cla_group(x[gi*GROUP +: GROUP], y[gi*GROUP +: GROUP], c);
            s[gi*GROUP +: GROUP] = r[GROUP-1:0];
            c = r[GROUP];
        end
        return {c, s};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [HALF:0]    lo_res;
    logic [HALF:0]    hi_res;
    logic             s2_free;
    logic             ovf_next;

    logic             s1_valid_reg;
    logic [HALF-1:0]  s1_lo_sum_reg;
    logic             s1_lo_cout_reg;
    logic [HALF-1:0]  s1_a_hi_reg;
    logic [HALF-1:0]  s1_b_hi_reg;

    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub ? 1'b1 : cin;
    assign lo_res   = cla_half(a[HALF-1:0], b_eff[HALF-1:0], c_eff);
    assign hi_res   = cla_half(s1_a_hi_reg, s1_b_hi_reg, s1_lo_cout_reg);
    assign ovf_next = (s1_a_hi_reg[HALF-1] == s1_b_hi_reg[HALF-1]) &&
                      (hi_res[HALF-1] != s1_a_hi_reg[HALF-1]);

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid_reg || s2_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            out_valid    <= 1'b0;
            sum          <= '0;
            cout         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (s2_free) begin
                out_valid <= s1_valid_reg;
            end
            if (s1_valid_reg && s2_free) begin
                sum  <= {hi_res[HALF-1:0], s1_lo_sum_reg};
                cout <= hi_res[HALF];
                ovf  <= ovf_next;
            end
        end
    end

    // S1 payload carries no reset; its valid bit alone qualifies it.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_lo_sum_reg  <= lo_res[HALF-1:0];
            s1_lo_cout_reg <= lo_res[HALF];
            s1_a_hi_reg    <= a[WIDTH-1:HALF];
            s1_b_hi_reg    <= b_eff[WIDTH-1:HALF];
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed vector table, backpressure/reset sequences and a random in-order scoreboard for cla_pipe_adder.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t        vt[12];
    logic [17:0] exp_q[$];
    logic        hold_chk = 1'b0;
    logic [15:0] hold_sum;
    logic [1:0]  hold_flags;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum}
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic s);
        logic [15:0] be;
        logic [16:0] r;
        logic        ce;
        be = s ? ~y : y;
        ce = s ? 1'b1 : ci;
        r  = {1'b0, x} + {1'b0, be} + {16'b0, ce};
        return {(x[15] == be[15]) && (r[15] != x[15]), r[16], r[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // One clock cycle of stimulus, sampled at negedge+1; scoreboard tracks accepted operands.
    task automatic cycle(input logic iv, input logic [15:0] ta, input logic [15:0] tbv,
                         input logic tc, input logic ts, input logic ordy,
                         output logic acc, output logic pop);
        logic [17:0] e;
        in_valid  = iv;
        a         = ta;
        b         = tbv;
        cin       = tc;
        sub       = ts;
        out_ready = ordy;
        #1;
        if (hold_chk) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, hold_sum);
            chk("hold_flags", {cout, ovf}, hold_flags);
        end
        pop = out_valid && out_ready;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_sum", sum, e[15:0]);
                chk("out_flags", {cout, ovf}, {e[16], e[17]});
                $display("out #%0d sum=%04h cout=%0b ovf=%0b", n_out, sum, cout, ovf);
                n_out++;
            end
        end
        hold_chk   = out_valid && !out_ready;
        hold_sum   = sum;
        hold_flags = {cout, ovf};
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(ref_add(ta, tbv, tc, ts));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic acc, pop;
        int   n_acc, cyc;

        vt[0]  = '{16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0};
        vt[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[5]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[10] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vt[11] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Table: one operand at a time, result expected two edges after presentation.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub;
            out_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("lat_early_valid", out_valid, 0);
            @(posedge clk); @(negedge clk);
            #1;
            chk("vec_valid", out_valid, 1);
            chk("vec_sum", sum, vt[i].sum);
            chk("vec_cout", cout, vt[i].cout);
            chk("vec_ovf", ovf, vt[i].ovf);
            $display("vec %0d a=%04h b=%04h cin=%0b sub=%0b -> sum=%04h cout=%0b ovf=%0b",
                     i, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, sum, cout, ovf);
        end
        @(posedge clk); @(negedge clk);

        // Backpressure: two accepted, then in_ready low until the consumer drains.
        cycle(1, vt[0].a, vt[0].b, vt[0].cin, vt[0].sub, 0, acc, pop); chk("bp_acc0", acc, 1);
        cycle(1, vt[1].a, vt[1].b, vt[1].cin, vt[1].sub, 0, acc, pop); chk("bp_acc1", acc, 1);
        cycle(1, vt[2].a, vt[2].b, vt[2].cin, vt[2].sub, 0, acc, pop); chk("bp_stall0", acc, 0);
        cycle(1, vt[2].a, vt[2].b, vt[2].cin, vt[2].sub, 0, acc, pop); chk("bp_stall1", acc, 0);
        cycle(1, vt[2].a, vt[2].b, vt[2].cin, vt[2].sub, 1, acc, pop);
        chk("bp_acc2", acc, 1); chk("bp_pop0", pop, 1);
        cycle(1, vt[3].a, vt[3].b, vt[3].cin, vt[3].sub, 1, acc, pop);
        chk("bp_acc3", acc, 1); chk("bp_pop1", pop, 1);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1, acc, pop); chk("bp_pop2", pop, 1);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1, acc, pop); chk("bp_pop3", pop, 1);
        chk("bp_drained", exp_q.size(), 0);

        // Reset with both stages full.
        cycle(1, vt[0].a, vt[0].b, vt[0].cin, vt[0].sub, 0, acc, pop);
        cycle(1, vt[1].a, vt[1].b, vt[1].cin, vt[1].sub, 0, acc, pop);
        in_valid = 1'b0;
        #2;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_flags", {cout, ovf}, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        hold_chk = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        repeat (3) begin
            cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1, acc, pop);
            chk("post_rst_no_stale", pop, 0);
        end
        cycle(1, vt[5].a, vt[5].b, vt[5].cin, vt[5].sub, 1, acc, pop);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1, acc, pop); chk("post_rst_early", pop, 0);
        cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1, acc, pop); chk("post_rst_first", pop, 1);

        // Random traffic against the scoreboard.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), acc, pop);
            if (acc) n_acc++;
            cyc++;
        end
        chk("rand_accepted", n_acc, 10000);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 10) begin
            cycle(0, 16'h0, 16'h0, 1'b0, 1'b0, 1, acc, pop);
            cyc++;
        end
        chk("rand_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
